rptr_rempty_sync: RTL and testbench

- Next-generation read-side pointer/flag controller for the async FIFO.
- Adds the following to the basic read-pointer/empty block:
  - integrated N-stage synchroniser for the write-domain gray pointer;
  - gray-to-binary conversion;
  - registered read-side fill level;
  - programmable almost-empty flag;
  - sticky underflow detection.
- Sits in the rclk domain between the dual-port RAM read port and the wptr crossing. Drives the RAM read address and returns its gray pointer to the write side.

---
 rtl/fifo_pkg.sv | 29 ++
 rtl/rptr_rempty_sync_if.sv | 24 ++
 rtl/sync_bus.sv | 36 +++
 rtl/rptr_rempty_sync.sv | 85 ++++++++
 tb/tb_rptr_rempty_sync.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared async-FIFO pointer helpers
package fifo_pkg;

  // Widest pointer the helpers handle; narrower values are passed zero-extended.
  localparam int MAX_W = 16;

  function automatic int ptr_width(input int awidth);
    return awidth + 1;
  endfunction

  function automatic int depth_of(input int awidth);
    return 1 << awidth;
  endfunction

  // XOR prefix from the MSB; zero upper bits leave the result unchanged.
  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
    logic [MAX_W-1:0] b;
    b = g;
    for (int i = MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/rptr_rempty_sync_if.sv
// rtl/rptr_rempty_sync_if.sv - read-side request/status bundle
interface rptr_rempty_sync_if #(
  parameter int AWIDTH = 3
);
  logic              rinc;
  logic              uf_clr;
  logic [AWIDTH:0]   ae_thresh;
  logic              ren;
  logic [AWIDTH-1:0] raddr;
  logic              rempty;
  logic              ralmost_empty;
  logic [AWIDTH:0]   rlevel;
  logic              runderflow;

  modport master (
    output rinc, uf_clr, ae_thresh,
    input  ren, raddr, rempty, ralmost_empty, rlevel, runderflow
  );

  modport slave (
    input  rinc, uf_clr, ae_thresh,
    output ren, raddr, rempty, ralmost_empty, rlevel, runderflow
  );
endinterface

// File: rtl/sync_bus.sv
// rtl/sync_bus.sv - plain multi-flop bus synchroniser, async active-low reset to 0
module sync_bus #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [STAGES];
  logic [WIDTH-1:0] stage_d [STAGES];

  always_comb begin
    stage_d[0] = d;
    for (int i = 1; i < STAGES; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/rptr_rempty_sync.sv
// rtl/rptr_rempty_sync.sv - read pointer, empty/almost-empty/level/underflow for the async FIFO
module rptr_rempty_sync
  import fifo_pkg::*;
#(
  parameter int AWIDTH      = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic            rclk,
  input  logic            rrst_n,
  input  logic [AWIDTH:0] wptr,
  output logic [AWIDTH:0] rptr,
  rptr_rempty_sync_if.slave rd
);

  localparam int PW = ptr_width(AWIDTH);

  logic [PW-1:0] wq;
  logic [PW-1:0] wbin;
  logic [PW-1:0] bnext;
  logic [PW-1:0] gnext;
  logic [PW-1:0] level_next;
  logic          ren_c;

  logic [PW-1:0] bin_q, bin_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic          rempty_q, rempty_d;
  logic          rae_q, rae_d;
  logic [PW-1:0] rlevel_q, rlevel_d;
  logic          ruf_q, ruf_d;

  sync_bus #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_wptr_sync (
    .clk   (rclk),
    .rst_n (rrst_n),
    .d     (wptr),
    .q     (wq)
  );

  // Flags use bnext against the current wq, so they can only err towards empty.
  always_comb begin
    ren_c      = rd.rinc & ~rempty_q;
    bnext      = bin_q + PW'(ren_c);
    gnext      = PW'(bin2gray(MAX_W'(bnext)));
    wbin       = PW'(gray2bin(MAX_W'(wq)));
    level_next = wbin - bnext;

    bin_d      = bnext;
    rptr_d     = gnext;
    rempty_d   = (gnext == wq);
    rlevel_d   = level_next;
    rae_d      = (level_next <= rd.ae_thresh);
    ruf_d      = ruf_q;
    if (rd.uf_clr) ruf_d = 1'b0;
    if (rd.rinc && rempty_q) ruf_d = 1'b1;
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      bin_q    <= '0;
      rptr_q   <= '0;
      rempty_q <= 1'b1;
      rae_q    <= 1'b1;
      rlevel_q <= '0;
      ruf_q    <= 1'b0;
    end else begin
      bin_q    <= bin_d;
      rptr_q   <= rptr_d;
      rempty_q <= rempty_d;
      rae_q    <= rae_d;
      rlevel_q <= rlevel_d;
      ruf_q    <= ruf_d;
    end
  end

  assign rptr             = rptr_q;
  assign rd.ren           = ren_c;
  assign rd.raddr         = bin_q[AWIDTH-1:0];
  assign rd.rempty        = rempty_q;
  assign rd.ralmost_empty = rae_q;
  assign rd.rlevel        = rlevel_q;
  assign rd.runderflow    = ruf_q;

endmodule

// File: tb/tb_rptr_rempty_sync.sv
// tb/tb_rptr_rempty_sync.sv - directed scoreboard bench for rptr_rempty_sync
module tb_rptr_rempty_sync;

  localparam int AW = 3;
  localparam int SS = 2;

  typedef struct {
    logic       e;
    logic       ae;
    logic [3:0] lvl;
    logic       uf;
    logic [3:0] ptr;
  } exp_t;

  logic       rclk = 1'b0;
  logic       rrst_n = 1'b0;
  logic       clk_en = 1'b1;
  logic [3:0] wptr = 4'd0;
  logic [3:0] rptr;

  rptr_rempty_sync_if #(.AWIDTH(AW)) rif ();

  rptr_rempty_sync #(
    .AWIDTH      (AW),
    .SYNC_STAGES (SS)
  ) dut (
    .rclk   (rclk),
    .rrst_n (rrst_n),
    .wptr   (wptr),
    .rptr   (rptr),
    .rd     (rif.slave)
  );

  always begin
    #5;
    if (clk_en) rclk = ~rclk;
  end

  int   total = 0;
  int   bad = 0;
  exp_t sb[$];

  logic [3:0] wcnt = 4'd0;
  logic [3:0] rcnt = 4'd0;
  logic [3:0] pipe [SS];
  logic       m_empty = 1'b1;
  logic       m_ae = 1'b1;
  logic       m_uf = 1'b0;
  logic [3:0] thresh = 4'd0;

  function automatic logic [3:0] g4(input logic [3:0] b);
    return b ^ {1'b0, b[3:1]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    wcnt = 4'd0;
    rcnt = 4'd0;
    for (int i = 0; i < SS; i++) pipe[i] = 4'd0;
    m_empty = 1'b1;
    m_ae = 1'b1;
    m_uf = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rempty"}, rif.rempty, 1);
    chk({tag, "_rae"}, rif.ralmost_empty, 1);
    chk({tag, "_rlevel"}, rif.rlevel, 0);
    chk({tag, "_ruf"}, rif.runderflow, 0);
    chk({tag, "_rptr"}, rptr, 0);
    chk({tag, "_raddr"}, rif.raddr, 0);
  endtask

  // One rclk cycle: pre-edge checks on the combinational outputs, then scoreboard the registered ones.
  task automatic cycle(input logic inc, input logic clr);
    exp_t       e;
    exp_t       got;
    logic       ex_ren;
    logic [3:0] lvl;
    rif.rinc      = inc;
    rif.uf_clr    = clr;
    rif.ae_thresh = thresh;
    wptr          = g4(wcnt);
    #1;
    ex_ren = inc & ~m_empty;
    chk("ren", rif.ren, ex_ren);
    chk("raddr", rif.raddr, rcnt[2:0]);
    if (ex_ren) rcnt = rcnt + 4'd1;
    lvl     = pipe[SS-1] - rcnt;
    m_uf    = (inc & m_empty) | (m_uf & ~clr);
    m_empty = (lvl == 4'd0);
    m_ae    = (lvl <= thresh);
    e.e   = m_empty;
    e.ae  = m_ae;
    e.lvl = lvl;
    e.uf  = m_uf;
    e.ptr = g4(rcnt);
    sb.push_back(e);
    for (int i = SS - 1; i > 0; i--) pipe[i] = pipe[i-1];
    pipe[0] = wcnt;
    @(posedge rclk);
    #1;
    chk("sb_nonempty", sb.size(), 1);
    if (sb.size() != 0) begin
      got = sb.pop_front();
      chk("rempty", rif.rempty, got.e);
      chk("ralmost_empty", rif.ralmost_empty, got.ae);
      chk("rlevel", rif.rlevel, got.lvl);
      chk("runderflow", rif.runderflow, got.uf);
      chk("rptr", rptr, got.ptr);
    end
    rif.rinc   = 1'b0;
    rif.uf_clr = 1'b0;
  endtask

  initial begin
    rif.rinc      = 1'b0;
    rif.uf_clr    = 1'b0;
    rif.ae_thresh = 4'd0;
    model_reset();

    #12;
    chk_reset_outputs("reset");
    rrst_n = 1'b1;

    // underflow on empty FIFO, then clear
    cycle(1'b1, 1'b0);
    chk("uf_raddr_hold", rif.raddr, 0);
    cycle(1'b0, 1'b1);

    // five writes become visible after SYNC_STAGES+1 edges
    thresh = 4'd2;
    wcnt = 4'd5;
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    chk("empty_before_3rd_edge", rif.rempty, 1);
    cycle(1'b0, 1'b0);
    chk("level5", rif.rlevel, 5);
    chk("ae_level5", rif.ralmost_empty, 0);

    // three back-to-back reads, then drain
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0);
    chk("level2_ae", rif.ralmost_empty, 1);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);

    // two full-depth passes through the pointer space
    for (int pass = 0; pass < 2; pass++) begin
      wcnt = wcnt + 4'd8;
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0);
      chk("full_level", rif.rlevel, 8);
      for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0);
      chk("drained_empty", rif.rempty, 1);
    end

    // set beats clear in the same cycle
    cycle(1'b1, 1'b1);
    chk("uf_set_wins", rif.runderflow, 1);
    cycle(1'b0, 1'b1);

    // advance to bin=6, then async reset with the clock stopped
    wcnt = wcnt + 4'd1;
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    chk("pre_reset_rptr", rptr, 4'b0101);
    clk_en = 1'b0;
    #3;
    rrst_n = 1'b0;
    wptr = 4'd0;
    #2;
    chk_reset_outputs("async_reset");
    model_reset();
    #2;
    rrst_n = 1'b1;
    clk_en = 1'b1;

    // first read after release blocks until a new wptr arrives
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b1);
    thresh = 4'd0;
    wcnt = 4'd1;
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0);
    chk("ae_eq_empty_thresh0", rif.ralmost_empty, rif.rempty);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
